led_trail_pwm: RTL and testbench

Downstream output stage for the running-light chain. It takes the 8-bit one-hot LED pattern from the shifter and drives the physical LED pins through per-channel PWM. A lit channel is driven at full brightness. Once its bit drops, the channel fades out linearly, which gives the running light a "comet tail".

---
 rtl/led_trail_pwm_if.sv | 24 ++
 rtl/led_trail_pwm.sv | 128 ++++++++++++
 tb/tb_led_trail_pwm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/led_trail_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_trail_pwm_if
//  Purpose  : LED pattern in / PWM drive out bundle for led_trail_pwm.
//  Revision : 1.0  initial release
// ============================================================================
interface led_trail_pwm_if;
    logic [7:0] led_in;
    logic [7:0] led_out;
    logic       pwm_sync;

    modport master (
        output led_in,
        input  led_out,
        input  pwm_sync
    );

    modport slave (
        input  led_in,
        output led_out,
        output pwm_sync
    );
endinterface
`default_nettype wire

// File: rtl/led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : led_trail_pwm
//  Purpose  : Per-channel PWM LED driver with linear "comet tail" fade-out.
//             Optional gamma duty mapping via macro LED_TRAIL_GAMMA_EN.
//  Revision : 1.0  initial release
// ============================================================================
module led_trail_pwm #(
    parameter int DECAY_DIV  = 195312,
    parameter int DECAY_STEP = 16
) (
    input  wire logic      clk_50m,
    input  wire logic      rst,
    led_trail_pwm_if.slave bus
);

    localparam int         c_PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [7:0] c_STEP     = 8'(DECAY_STEP);
    localparam logic [7:0] c_PWM_LAST = 8'd254;
    localparam logic [7:0] c_FULL     = 8'hFF;

    logic [7:0]         r_s1;
    logic [7:0]         r_s2;
    logic [c_PRE_W-1:0] r_pre_cnt;
    logic               w_decay_tick;
    logic [7:0]         r_pwm_cnt;
    logic               w_shadow_load;
    logic [7:0]         r_level     [8];
    logic [7:0]         r_duty      [8];
    logic [7:0]         w_duty_next [8];
    logic [7:0]         r_led_out;
    logic               r_pwm_sync;

    // led_in comes from a derived clock domain: two-flop synchronizer per bit
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= bus.led_in;
            r_s2 <= r_s1;
        end
    end

    assign w_decay_tick = (r_pre_cnt == c_PRE_W'(DECAY_DIV - 1));

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_decay_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
        end
    end

    // 255-cycle period so that duty 255 yields a constantly-lit output
    assign w_shadow_load = (r_pwm_cnt == c_PWM_LAST);

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= 8'h00;
        end else if (w_shadow_load) begin
            r_pwm_cnt <= 8'h00;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // A set input always wins over a decay step landing on the same cycle
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_level[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_s2[i]) begin
                    r_level[i] <= c_FULL;
                end else if (w_decay_tick) begin
                    r_level[i] <= (r_level[i] > c_STEP) ? (r_level[i] - c_STEP) : 8'h00;
                end
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
`ifdef LED_TRAIL_GAMMA_EN
        logic [15:0] w_sq;
        assign w_sq            = 16'(r_level[gi]) * 16'(r_level[gi]) + 16'd255;
        assign w_duty_next[gi] = 8'(w_sq >> 8);
`else
        assign w_duty_next[gi] = r_level[gi];
`endif
    end

    // Duty only changes at the period boundary, keeping every pulse whole
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_duty[i] <= 8'h00;
            end
            r_pwm_sync <= 1'b0;
        end else begin
            if (w_shadow_load) begin
                for (int i = 0; i < 8; i++) begin
                    r_duty[i] <= w_duty_next[i];
                end
            end
            r_pwm_sync <= w_shadow_load;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_led_out <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_led_out[i] <= (r_pwm_cnt < r_duty[i]);
            end
        end
    end

    assign bus.led_out  = r_led_out;
    assign bus.pwm_sync = r_pwm_sync;

endmodule
`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_trail_pwm
//  Purpose  : Randomized self-checking bench for led_trail_pwm against a
//             closed-form fade model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_trail_pwm;

    localparam int c_DIV    = 4;
    localparam int c_STEP   = 64;
    localparam int c_PERIOD = 255;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;

    led_trail_pwm_if bus ();

    led_trail_pwm #(
        .DECAY_DIV  (c_DIV),
        .DECAY_STEP (c_STEP)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 clk_50m = ~clk_50m;

    int n_total = 0;
    int n_pass  = 0;

    // Model state: edge index since reset release, the 2-deep input history
    // and, per channel, the edge at which the level was last forced to 255.
    int         edge_n;
    logic [7:0] d1, d2;
    int         last_set [8];
    int         exp_duty [8];

    function automatic int f_model(input int x);
`ifdef LED_TRAIL_GAMMA_EN
        return (x * x + 255) / 256;
`else
        return x;
`endif
    endfunction

    // Level after edge e: 255 minus STEP per decay tick (edges that are
    // multiples of DIV) elapsed since the last set, floored at 0.
    function automatic int level_at(input int ls, input int e);
        int t, v;
        if (ls == 0) return 0;
        t = e / c_DIV - ls / c_DIV;
        v = 255 - c_STEP * t;
        return (v < 0) ? 0 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_50m);
        if (rst) begin
            edge_n = 0;
            d1 = 8'h00;
            d2 = 8'h00;
            for (int i = 0; i < 8; i++) begin
                last_set[i] = 0;
                exp_duty[i] = 0;
            end
        end else begin
            edge_n++;
            if (edge_n % c_PERIOD == 0) begin
                for (int i = 0; i < 8; i++) exp_duty[i] = f_model(level_at(last_set[i], edge_n - 1));
            end
            for (int i = 0; i < 8; i++) begin
                if (d2[i]) last_set[i] = edge_n;
            end
            d2 = d1;
            d1 = bus.led_in;
        end
        #1;
    endtask

    // From reset release: outputs dark, then the first sync exactly 255 edges in.
    task automatic after_reset_check();
        int budget = 300;
        while (bus.pwm_sync !== 1'b1 && budget > 0) begin
            tick();
            if (bus.led_out !== 8'h00) check("dark_before_first_load", bus.led_out, 8'h00);
            budget--;
        end
        check("first_sync_seen", budget > 0, 1);
        check("first_sync_edge", edge_n, c_PERIOD);
        check("led_out_at_first_sync", bus.led_out, 8'h00);
    endtask

    task automatic measure_period(input int kind);
        int          hi  [8];
        int          exp [8];
        int          r0;
        logic [7:0]  pat;
        logic [7:0]  mask;
        int          sh;
        int          budget;
        budget = 300;
        while (bus.pwm_sync !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check("sync_seen", budget > 0, 1);
        check("sync_phase", edge_n % c_PERIOD, 0);
        for (int i = 0; i < 8; i++) begin
            hi[i]  = 0;
            exp[i] = exp_duty[i];
        end
        r0   = $urandom_range(225, 241);
        pat  = 8'($urandom);
        mask = 8'($urandom);
        sh   = $urandom_range(0, 7);
        for (int j = 0; j < c_PERIOD; j++) begin
            case (kind)
                0: if (j == r0 - 100) bus.led_in = pat;
                1: if (j == r0) bus.led_in = bus.led_in & mask;
                2: begin
                    if (j == 0)       bus.led_in = 8'h00;
                    if (j == r0)      bus.led_in = 8'(1 << sh);
                    if (j == r0 + 5)  bus.led_in = 8'(1 << ((sh + 1) % 8));
                    if (j == r0 + 10) bus.led_in = 8'(1 << ((sh + 2) % 8));
                end
                3: if (j == 0) bus.led_in = 8'hFF;
                default: begin
                    if (j == 0)      bus.led_in = 8'h08;
                    if (j == 200)    bus.led_in = 8'h00;
                    if (j == 200 + 2 + int'(pat[1:0])) bus.led_in = 8'h08;
                    if (j == r0)     bus.led_in = 8'h00;
                end
            endcase
            tick();
            for (int i = 0; i < 8; i++) hi[i] += int'(bus.led_out[i]);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("high_count_k%0d_ch%0d", kind, i), hi[i], exp[i]);
        end
    endtask

    initial begin
        bus.led_in = 8'hFF;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("reset_led_out", bus.led_out, 8'h00);
            check("reset_pwm_sync", bus.pwm_sync, 1'b0);
        end
        rst = 1'b0;
        after_reset_check();

        // Full-on period directly after the first load: channel 0 lit all period
        bus.led_in = 8'h01;
        measure_period(4'd3 == 4'd3 ? 1 : 1);
        for (int p = 0; p < 24; p++) begin
            measure_period(int'($urandom_range(0, 4)));
        end

        // Reset mid-period clears outputs immediately, without waiting for an edge
        repeat (37) tick();
        rst = 1'b1;
        #1;
        check("async_reset_led_out", bus.led_out, 8'h00);
        check("async_reset_pwm_sync", bus.pwm_sync, 1'b0);
        tick();
        tick();
        bus.led_in = 8'($urandom);
        rst = 1'b0;
        after_reset_check();

        for (int p = 0; p < 16; p++) begin
            measure_period(p % 5);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
